// File: rtl/step_dir_decoder.sv
// Receiving end of a step/dir/enable stepper interface: synchronises the lines,
// rejects short step pulses, tracks signed position and measures step period.
module step_dir_decoder #(
  parameter int POS_WIDTH = 16,
  parameter int PER_WIDTH = 17,
  parameter int MIN_HIGH  = 25,
  parameter int DIR_SETUP = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        step_in,
  input  logic                        dir_in,
  input  logic                        en_in,
  input  logic                        pos_clr,
  input  logic                        err_clr,
  output logic signed [POS_WIDTH-1:0] pos,
  output logic                        step_valid,
  output logic [PER_WIDTH-1:0]        period,
  output logic                        period_valid,
  output logic                        moving,
  output logic                        err_glitch,
  output logic                        err_setup
);

  localparam int HCNT_W = $clog2(MIN_HIGH + 1);
  localparam int DCNT_W = $clog2(DIR_SETUP + 1);
  localparam logic [HCNT_W-1:0]           HCNT_MAX = HCNT_W'(MIN_HIGH);
  localparam logic [HCNT_W-1:0]           HCNT_ONE = HCNT_W'(1);
  localparam logic [DCNT_W-1:0]           DCNT_MAX = DCNT_W'(DIR_SETUP);
  localparam logic [DCNT_W-1:0]           DCNT_ONE = DCNT_W'(1);
  localparam logic [PER_WIDTH-1:0]        PCNT_SAT = '1;
  localparam logic [PER_WIDTH-1:0]        PCNT_ONE = PER_WIDTH'(1);
  localparam logic signed [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH_CHK, WAIT_LOW} state_t;

  function automatic logic [PER_WIDTH-1:0] pcnt_inc(input logic [PER_WIDTH-1:0] v);
    return (v == PCNT_SAT) ? v : v + PCNT_ONE;
  endfunction

  function automatic logic [DCNT_W-1:0] dcnt_inc(input logic [DCNT_W-1:0] v);
    return (v == DCNT_MAX) ? v : v + DCNT_ONE;
  endfunction

  logic [1:0]                  step_sync_q, dir_sync_q, en_sync_q;
  logic                        s_step, s_dir, s_en;
  logic                        step_prev_q;
  state_t                      state_q, state_d;
  logic [HCNT_W-1:0]           hcnt_q, hcnt_d;
  logic [DCNT_W-1:0]           dcnt_q, dcnt_d;
  logic                        dir_lat_q, dir_lat_d;
  logic                        first_q, first_d;
  logic signed [POS_WIDTH-1:0] pos_q, pos_d;
  logic [PER_WIDTH-1:0]        pcnt_q, pcnt_d;
  logic [PER_WIDTH-1:0]        period_q, period_d;
  logic                        step_valid_q, step_valid_d;
  logic                        period_valid_q, period_valid_d;
  logic                        err_glitch_q, err_glitch_d;
  logic                        err_setup_q, err_setup_d;
  logic                        accept, glitch_evt, setup_evt;

  assign s_step = step_sync_q[1];
  assign s_dir  = dir_sync_q[1];
  assign s_en   = en_sync_q[1];

  always_comb begin
    state_d        = state_q;
    hcnt_d         = hcnt_q;
    dir_lat_d      = dir_lat_q;
    first_d        = first_q;
    pos_d          = pos_q;
    period_d       = period_q;
    step_valid_d   = 1'b0;
    period_valid_d = 1'b0;
    accept         = 1'b0;
    glitch_evt     = 1'b0;
    setup_evt      = 1'b0;
    // Restart the dir-stable count on the cycle the synchronised dir changes.
    dcnt_d         = (dir_sync_q[0] != s_dir) ? '0 : dcnt_inc(dcnt_q);
    pcnt_d         = pcnt_inc(pcnt_q);

    if (!s_en) begin
      state_d = IDLE;
      first_d = 1'b1;
    end else begin
      case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: begin
          if (s_step && !step_prev_q) begin
            dir_lat_d = s_dir;
            setup_evt = (dcnt_q < DCNT_MAX);
            hcnt_d    = HCNT_ONE;
            state_d   = HIGH_CHK;
          end
        end
        HIGH_CHK: begin
          if (!s_step) begin
            glitch_evt = 1'b1;
            state_d    = ARMED;
          end else if (hcnt_q == HCNT_MAX) begin
            accept  = 1'b1;
            state_d = WAIT_LOW;
          end else begin
            hcnt_d = hcnt_q + HCNT_ONE;
          end
        end
        WAIT_LOW: if (!s_step) state_d = ARMED;
        default:  state_d = IDLE;
      endcase
    end

    if (accept) begin
      step_valid_d = 1'b1;
      pos_d        = dir_lat_q ? pos_q + POS_ONE : pos_q - POS_ONE;
      pcnt_d       = PCNT_ONE;
      first_d      = 1'b0;
      if (!first_q) begin
        period_d       = pcnt_q;
        period_valid_d = 1'b1;
      end
    end
    if (pos_clr) pos_d = '0;

    err_glitch_d = glitch_evt | (err_glitch_q & ~err_clr);
    err_setup_d  = setup_evt  | (err_setup_q  & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_sync_q    <= '0;
      dir_sync_q     <= '0;
      en_sync_q      <= '0;
      step_prev_q    <= 1'b0;
      state_q        <= IDLE;
      hcnt_q         <= '0;
      dcnt_q         <= '0;
      dir_lat_q      <= 1'b0;
      first_q        <= 1'b1;
      pos_q          <= '0;
      pcnt_q         <= PCNT_SAT;
      period_q       <= '0;
      step_valid_q   <= 1'b0;
      period_valid_q <= 1'b0;
      err_glitch_q   <= 1'b0;
      err_setup_q    <= 1'b0;
    end else begin
      step_sync_q    <= {step_sync_q[0], step_in};
      dir_sync_q     <= {dir_sync_q[0], dir_in};
      en_sync_q      <= {en_sync_q[0], en_in};
      step_prev_q    <= s_step;
      state_q        <= state_d;
      hcnt_q         <= hcnt_d;
      dcnt_q         <= dcnt_d;
      dir_lat_q      <= dir_lat_d;
      first_q        <= first_d;
      pos_q          <= pos_d;
      pcnt_q         <= pcnt_d;
      period_q       <= period_d;
      step_valid_q   <= step_valid_d;
      period_valid_q <= period_valid_d;
      err_glitch_q   <= err_glitch_d;
      err_setup_q    <= err_setup_d;
    end
  end

  assign pos          = pos_q;
  assign step_valid   = step_valid_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign moving       = (pcnt_q != PCNT_SAT) && (state_q != IDLE);
  assign err_glitch   = err_glitch_q;
  assign err_setup    = err_setup_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Randomised and directed bench for step_dir_decoder against a window-based
// model of accepted steps, plus literal expectations for the headline cases.
module tb_step_dir_decoder;
  localparam int MIN_HIGH  = 25;
  localparam int DIR_SETUP = 10;
  localparam int PMAX      = (1 << 17) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step_in = 1'b0, dir_in = 1'b0, en_in = 1'b0;
  logic pos_clr = 1'b0, err_clr = 1'b0, ps_clr = 1'b0;
  logic [15:0] pos;
  logic [16:0] period;
  logic step_valid, period_valid, moving, err_glitch, err_setup;
  logic [3:0]  pos_s;
  logic [16:0] period_s;
  logic sv_s, pv_s, mv_s, eg_s, es_s;

  always #10 clk = ~clk;

  step_dir_decoder #(.POS_WIDTH(16), .PER_WIDTH(17), .MIN_HIGH(MIN_HIGH), .DIR_SETUP(DIR_SETUP)) u_dut (
    .clk(clk), .rst(rst), .step_in(step_in), .dir_in(dir_in), .en_in(en_in),
    .pos_clr(pos_clr), .err_clr(err_clr), .pos(pos), .step_valid(step_valid),
    .period(period), .period_valid(period_valid), .moving(moving),
    .err_glitch(err_glitch), .err_setup(err_setup));

  // Narrow instance so the positive signed wrap is reachable in few steps.
  step_dir_decoder #(.POS_WIDTH(4), .PER_WIDTH(17), .MIN_HIGH(2), .DIR_SETUP(2)) u_small (
    .clk(clk), .rst(rst), .step_in(step_in), .dir_in(dir_in), .en_in(en_in),
    .pos_clr(ps_clr), .err_clr(1'b0), .pos(pos_s), .step_valid(sv_s),
    .period(period_s), .period_valid(pv_s), .moving(mv_s),
    .err_glitch(eg_s), .err_setup(es_s));

  // Behavioural model: inputs are seen two edges late; a step is a rise seen
  // while enabled, followed by MIN_HIGH more enabled high samples.
  int   n = 0, dir_chg = 0, rise_n = 0, last_acc = 0;
  logic d1s = 0, d2s = 0, d1d = 0, d2d = 0, d1e = 0, d2e = 0;
  logic pc_step = 0, pc_dir = 0, pc_en = 0;
  logic pend = 0, lat_dir = 0, m_first = 1, have_acc = 0;
  logic [15:0] m_pos = 0;
  logic [16:0] m_period = 0;
  logic m_sv = 0, m_pv = 0, m_moving = 0, m_eg = 0, m_es = 0;

  always @(posedge clk) begin
    logic cs, cd, ce, g, s, acc;
    n++;
    if (rst) begin
      {d1s, d2s, d1d, d2d, d1e, d2e} = '0;
      {pc_step, pc_dir, pc_en} = '0;
      dir_chg = n + 1; pend = 0; m_first = 1; have_acc = 0;
      m_pos = 0; m_period = 0;
      {m_sv, m_pv, m_moving, m_eg, m_es} = '0;
    end else begin
      cs = d2s; cd = d2d; ce = d2e;
      d2s = d1s; d2d = d1d; d2e = d1e;
      d1s = step_in; d1d = dir_in; d1e = en_in;
      if (cd != pc_dir) dir_chg = n;
      g = 0; s = 0; acc = 0; m_sv = 0; m_pv = 0;
      if (!ce) begin
        pend = 0; m_first = 1;
      end else if (pend) begin
        if (!cs) begin g = 1; pend = 0; end
        else if (n - rise_n == MIN_HIGH) begin acc = 1; pend = 0; end
      end else if (pc_en && cs && !pc_step) begin
        pend = 1; rise_n = n; lat_dir = cd;
        s = ((n - dir_chg) < DIR_SETUP);
      end
      if (acc) begin
        m_sv = 1;
        m_pos = lat_dir ? m_pos + 16'd1 : m_pos - 16'd1;
        if (!m_first) begin
          m_pv = 1;
          m_period = 17'((n - last_acc) > PMAX ? PMAX : (n - last_acc));
        end
        m_first = 0; have_acc = 1; last_acc = n;
      end
      if (pos_clr) m_pos = 0;
      m_eg = g | (m_eg & ~err_clr);
      m_es = s | (m_es & ~err_clr);
      m_moving = ce && have_acc && ((n - last_acc + 1) < PMAX);
      pc_step = cs; pc_dir = cd; pc_en = ce;
    end
  end

  int checks = 0, errors = 0;
  int sv_cnt = 0, pv_cnt = 0;
  logic chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("pos", 32'(pos), 32'(m_pos));
    check("step_valid", 32'(step_valid), 32'(m_sv));
    check("period", 32'(period), 32'(m_period));
    check("period_valid", 32'(period_valid), 32'(m_pv));
    check("moving", 32'(moving), 32'(m_moving));
    check("err_glitch", 32'(err_glitch), 32'(m_eg));
    check("err_setup", 32'(err_setup), 32'(m_es));
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse(input int high, input int low);
    step_in = 1'b1; idle(high);
    step_in = 1'b0; idle(low);
  endtask

  task automatic strobe_pos_clr();
    pos_clr = 1'b1; idle(1); pos_clr = 1'b0;
  endtask

  task automatic strobe_err_clr();
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
  endtask

  initial begin
    int sv0, pv0;
    logic [15:0] p0;
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          compare_all();
          if (step_valid === 1'b1) sv_cnt++;
          if (period_valid === 1'b1) pv_cnt++;
        end
      end
    join_none

    idle(3);
    chk_en = 1;
    idle(1);
    rst = 1'b0;
    check("reset_pos", 32'(pos), 0);
    check("reset_period", 32'(period), 0);
    check("reset_flags", 32'({step_valid, period_valid, moving, err_glitch, err_setup}), 0);

    // Five steps forward at a 2000-cycle period.
    en_in = 1; dir_in = 1; idle(30);
    sv0 = sv_cnt; pv0 = pv_cnt;
    repeat (5) pulse(40, 1960);
    check("t1_pos", 32'(pos), 5);
    check("t1_model_pos", 32'(m_pos), 5);
    check("t1_sv_count", sv_cnt - sv0, 5);
    check("t1_pv_count", pv_cnt - pv0, 4);
    check("t1_period", 32'(period), 2000);
    check("t1_model_period", 32'(m_period), 2000);
    check("t1_moving", 32'(moving), 1);
    check("t1_errors", 32'({err_glitch, err_setup}), 0);

    // Reverse from zero, then positive signed wrap on the narrow instance.
    strobe_pos_clr();
    dir_in = 0; idle(30);
    repeat (3) pulse(40, 60);
    check("t2_pos_neg", 32'(pos), 32'h0000_FFFD);
    ps_clr = 1; idle(1); ps_clr = 0;
    dir_in = 1; idle(30);
    repeat (7) pulse(40, 60);
    check("t2_small_max", 32'(pos_s), 32'h7);
    pulse(40, 60);
    check("t2_small_wrap", 32'(pos_s), 32'h8);
    check("t2_pos_main", 32'(pos), 32'h5);

    // Short pulse is rejected and flagged.
    p0 = pos; sv0 = sv_cnt;
    pulse(10, 60);
    check("t3_glitch", 32'(err_glitch), 1);
    check("t3_pos_hold", 32'(pos), 32'(p0));
    check("t3_no_sv", sv_cnt - sv0, 0);
    strobe_err_clr(); idle(2);
    check("t3_glitch_clr", 32'(err_glitch), 0);

    // Direction changed 3 cycles before the rise, then held stable.
    p0 = pos;
    dir_in = 0; idle(3);
    pulse(40, 60);
    check("t4_setup_err", 32'(err_setup), 1);
    check("t4_pos_new_dir", 32'(pos), 32'(p0 - 16'd1));
    strobe_err_clr(); idle(20);
    pulse(40, 60);
    check("t4_setup_ok", 32'(err_setup), 0);
    check("t4_pos_again", 32'(pos), 32'(p0 - 16'd2));

    // Enable drops during the high check.
    p0 = pos; sv0 = sv_cnt;
    step_in = 1; idle(15); en_in = 0; idle(10); step_in = 0; idle(10);
    check("t5_pos_hold", 32'(pos), 32'(p0));
    check("t5_no_sv", sv_cnt - sv0, 0);
    check("t5_idle_moving", 32'(moving), 0);
    en_in = 1; idle(30);
    pv0 = pv_cnt;
    repeat (2) pulse(40, 460);
    check("t5_pv_once", pv_cnt - pv0, 1);
    check("t5_period", 32'(period), 500);

    // pos_clr on the accept edge, then reset mid-step.
    step_in = 1; idle(MIN_HIGH + 2);
    pos_clr = 1; idle(1); pos_clr = 0;
    check("t6_sv_on_clr", 32'(step_valid), 1);
    check("t6_pos_clr_wins", 32'(pos), 0);
    idle(12); step_in = 0; idle(60);
    dir_in = 1; idle(20);
    step_in = 1; idle(15);
    rst = 1; idle(1);
    check("t6_rst_pos", 32'(pos), 0);
    check("t6_rst_flags", 32'({step_valid, period_valid, moving, err_glitch, err_setup, period}), 0);
    rst = 0; idle(30); step_in = 0; idle(30);
    check("t6_discarded", 32'(pos), 0);

    // Randomised traffic.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 15) == 0) en_in = ~en_in;
      if ($urandom_range(0, 3) == 0) dir_in = ~dir_in;
      if ($urandom_range(0, 9) == 0) strobe_err_clr();
      if ($urandom_range(0, 19) == 0) strobe_pos_clr();
      idle($urandom_range(0, 12));
      pulse($urandom_range(5, 45), $urandom_range(1, 80));
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
